// File: rtl/camera_capture.sv
// camera_capture: samples an 8-bit sensor bus framed by VSYNC/HREF, packs
// byte pairs into RGB444 pixels and writes them to a frame buffer.
//
// Ports:
//   clk_i, reset_ni       pixel clock, async active-low reset
//   capture_en_i          arms capture, sampled at frame start only
//   vsync_i, href_i       sensor framing (vsync high = blanking)
//   pixel_data_i[7:0]     sensor byte
//   write_en_o            one-cycle frame-buffer write strobe
//   write_address_o       linear raster address 0..DEPTH-1
//   write_data_o          pixel {R[3:0],G[3:0],B[3:0]}
//   frame_done_o          one-cycle pulse at end of a captured frame
//   overflow_o            sticky: frame had more than DEPTH pixels
//   frame_count_o         captured-frame counter, wraps
//
// Optional build macro CAMERA_TEST_PATTERN_EN: write_data_o carries the
// pixel counter instead of sensor data; framing and addressing unchanged.

module camera_capture #(
    parameter int WIDTH      = 12,
    parameter int DEPTH      = 76800,
    parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
    input  logic                  clk_i,
    input  logic                  reset_ni,
    input  logic                  capture_en_i,
    input  logic                  vsync_i,
    input  logic                  href_i,
    input  logic [7:0]            pixel_data_i,
    output logic                  write_en_o,
    output logic [ADDR_WIDTH-1:0] write_address_o,
    output logic [WIDTH-1:0]      write_data_o,
    output logic                  frame_done_o,
    output logic                  overflow_o,
    output logic [7:0]            frame_count_o
);

    // Counter must be able to hold DEPTH itself so it can saturate there.
    localparam int CNT_W = $clog2(DEPTH + 1);

    typedef enum logic [1:0] {
        IDLE,
        WAIT_FRAME,
        ACTIVE
    } state_e;

    state_e                  state_q, state_d;
    logic                    vsync_prev_q, vsync_prev_d;
    logic                    phase_q, phase_d;
    logic [3:0]              red_q, red_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic                    we_q, we_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [WIDTH-1:0]        data_q, data_d;
    logic                    done_q, done_d;
    logic                    ovf_q, ovf_d;
    logic [7:0]              fcnt_q, fcnt_d;

    always_comb begin
        state_d      = state_q;
        vsync_prev_d = vsync_i;
        phase_d      = phase_q;
        red_d        = red_q;
        cnt_d        = cnt_q;
        we_d         = 1'b0;
        addr_d       = addr_q;
        data_d       = data_q;
        done_d       = 1'b0;
        ovf_d        = ovf_q;
        fcnt_d       = fcnt_q;

        unique case (state_q)
            // Wait for blanking so a partially seen frame is never captured.
            IDLE: begin
                if (vsync_i) begin
                    state_d = WAIT_FRAME;
                end
            end

            // Frame start is the vsync falling edge; a byte sampled on that
            // same edge belongs to no frame and is dropped.
            WAIT_FRAME: begin
                if (vsync_prev_q && !vsync_i && capture_en_i) begin
                    state_d = ACTIVE;
                    cnt_d   = '0;
                    phase_d = 1'b0;
                    ovf_d   = 1'b0;
                end
            end

            ACTIVE: begin
                if (vsync_i) begin
                    state_d = WAIT_FRAME;
                    phase_d = 1'b0;
                    done_d  = 1'b1;
                    fcnt_d  = fcnt_q + 8'd1;
                end else if (!href_i) begin
                    // Any dangling odd byte of the line is discarded here.
                    phase_d = 1'b0;
                end else if (!phase_q) begin
                    red_d   = pixel_data_i[3:0];
                    phase_d = 1'b1;
                end else begin
                    phase_d = 1'b0;
                    if (cnt_q < CNT_W'(DEPTH)) begin
                        we_d   = 1'b1;
                        addr_d = ADDR_WIDTH'(cnt_q);
`ifdef CAMERA_TEST_PATTERN_EN
                        data_d = WIDTH'(cnt_q);
`else
                        data_d = WIDTH'({red_q, pixel_data_i});
`endif
                        cnt_d  = cnt_q + CNT_W'(1);
                    end else begin
                        // Counter stays at DEPTH; excess pixels are dropped.
                        ovf_d = 1'b1;
                    end
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q      <= IDLE;
            vsync_prev_q <= 1'b0;
            phase_q      <= 1'b0;
            red_q        <= '0;
            cnt_q        <= '0;
            we_q         <= 1'b0;
            addr_q       <= '0;
            data_q       <= '0;
            done_q       <= 1'b0;
            ovf_q        <= 1'b0;
            fcnt_q       <= '0;
        end else begin
            state_q      <= state_d;
            vsync_prev_q <= vsync_prev_d;
            phase_q      <= phase_d;
            red_q        <= red_d;
            cnt_q        <= cnt_d;
            we_q         <= we_d;
            addr_q       <= addr_d;
            data_q       <= data_d;
            done_q       <= done_d;
            ovf_q        <= ovf_d;
            fcnt_q       <= fcnt_d;
        end
    end

    assign write_en_o      = we_q;
    assign write_address_o = addr_q;
    assign write_data_o    = data_q;
    assign frame_done_o    = done_q;
    assign overflow_o      = ovf_q;
    assign frame_count_o   = fcnt_q;

endmodule

// File: tb/tb_camera_capture.sv
// tb_camera_capture: randomized frames checked against a line/pixel-level
// reference model of the capture rules.

module tb_camera_capture;

    localparam int WIDTH = 12;
    localparam int DEPTH = 48;
    localparam int AW    = $clog2(DEPTH);

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          cap_en = 1'b0;
    logic          vsync = 1'b0;
    logic          href = 1'b0;
    logic [7:0]    pd = 8'h00;
    logic          we;
    logic [AW-1:0] addr;
    logic [WIDTH-1:0] wdata;
    logic          done;
    logic          ovf;
    logic [7:0]    fcnt;

    camera_capture #(
        .WIDTH     (WIDTH),
        .DEPTH     (DEPTH),
        .ADDR_WIDTH(AW)
    ) dut (
        .clk_i          (clk),
        .reset_ni       (rst_n),
        .capture_en_i   (cap_en),
        .vsync_i        (vsync),
        .href_i         (href),
        .pixel_data_i   (pd),
        .write_en_o     (we),
        .write_address_o(addr),
        .write_data_o   (wdata),
        .frame_done_o   (done),
        .overflow_o     (ovf),
        .frame_count_o  (fcnt)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Cycle index: number of rising edges so far.
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Monitor of DUT outputs, sampled on the falling edge.
    int   mon_addr[$];
    int   mon_data[$];
    int   mon_cyc[$];
    int   mon_done[$];
    int   b2b = 0;
    logic prev_we = 1'b0;

    always @(negedge clk) begin
        if (we === 1'b1) begin
            mon_addr.push_back(int'(addr));
            mon_data.push_back(int'(wdata));
            mon_cyc.push_back(cyc);
        end
        if (we === 1'b1 && prev_we === 1'b1) b2b++;
        prev_we = we;
        if (done === 1'b1) mon_done.push_back(cyc);
    end

    // Reference model state.
    int  ex_addr[$];
    int  ex_data[$];
    int  ex_cyc[$];
    int  line_b[$];
    int  line_c[$];
    int  stim[$];
    bit  captured;
    int  pix_n;
    int  exp_count = 0;
    bit  exp_ovf = 1'b0;

    // Drive one sample; c is the rising-edge index that will sample it.
    task automatic drive(input bit v, input bit h, input int d, output int c);
        @(negedge clk);
        vsync = v;
        href  = h;
        pd    = 8'(d);
        c     = cyc + 1;
    endtask

    // A line yields floor(n/2) pixels; each appears one cycle after its
    // second byte, at the next raster index, while below DEPTH.
    task automatic flush_line();
        int px;
        for (int k = 0; k + 1 < line_b.size(); k += 2) begin
            if (captured) begin
                if (pix_n < DEPTH) begin
`ifdef CAMERA_TEST_PATTERN_EN
                    px = pix_n & 'hFFF;
`else
                    px = ((line_b[k] & 'hF) << 8) | line_b[k+1];
`endif
                    ex_addr.push_back(pix_n);
                    ex_data.push_back(px);
                    ex_cyc.push_back(line_c[k+1]);
                end
                pix_n++;
            end
        end
        line_b.delete();
        line_c.delete();
    endtask

    task automatic add_line(input int npix, input bit odd);
        for (int i = 0; i < 2 * npix + int'(odd); i++)
            stim.push_back(int'($urandom_range(0, 255)));
        stim.push_back(-1);
    endtask

    task automatic do_frame(input bit en_start, input bit en_mid,
                            input bit rst_mid, input string name);
        int  c;
        int  end_c;
        int  n;
        bit  first_gap;
        captured  = en_start;
        pix_n     = 0;
        first_gap = 1'b1;
        cap_en    = en_start;
        drive(1, 0, $urandom_range(0, 255), c);
        drive(1, 0, $urandom_range(0, 255), c);
        // Falling vsync with href high: that byte must be ignored.
        drive(0, 1, $urandom_range(0, 255), c);
        foreach (stim[i]) begin
            if (stim[i] >= 0) begin
                drive(0, 1, stim[i], c);
                line_b.push_back(stim[i]);
                line_c.push_back(c);
            end else begin
                flush_line();
                n = 1 + int'($urandom_range(0, 1));
                for (int g = 0; g < n; g++)
                    drive(0, 0, $urandom_range(0, 255), c);
                if (first_gap) begin
                    cap_en = en_mid;
                    if (rst_mid) begin
                        @(negedge clk);
                        rst_n = 1'b0;
                        #1;
                        check({name, "_rst_we"}, int'(we), 0);
                        check({name, "_rst_cnt"}, int'(fcnt), 0);
                        check({name, "_rst_ovf"}, int'(ovf), 0);
                        check({name, "_rst_adr"}, int'(addr), 0);
                        @(negedge clk);
                        rst_n     = 1'b1;
                        captured  = 1'b0;
                        exp_count = 0;
                        exp_ovf   = 1'b0;
                    end
                end
                first_gap = 1'b0;
            end
        end
        drive(1, 0, $urandom_range(0, 255), end_c);
        drive(1, 0, $urandom_range(0, 255), c);
        drive(1, 0, $urandom_range(0, 255), c);
        if (captured) begin
            exp_count = (exp_count + 1) % 256;
            exp_ovf   = (pix_n > DEPTH);
        end
        check({name, "_nwr"}, mon_addr.size(), ex_addr.size());
        n = (mon_addr.size() < ex_addr.size()) ? mon_addr.size()
                                                : ex_addr.size();
        for (int i = 0; i < n; i++) begin
            check({name, "_adr"}, mon_addr[i], ex_addr[i]);
            check({name, "_dat"}, mon_data[i], ex_data[i]);
            check({name, "_cyc"}, mon_cyc[i], ex_cyc[i]);
        end
        check({name, "_ndone"}, mon_done.size(), captured ? 1 : 0);
        if (captured && mon_done.size() > 0)
            check({name, "_donecyc"}, mon_done[0], end_c);
        check({name, "_fcnt"}, int'(fcnt), exp_count);
        check({name, "_ovf"}, int'(ovf), int'(exp_ovf));
        check({name, "_b2b"}, b2b, 0);
        mon_addr.delete();
        mon_data.delete();
        mon_cyc.delete();
        mon_done.delete();
        ex_addr.delete();
        ex_data.delete();
        ex_cyc.delete();
        stim.delete();
    endtask

    initial begin
        int c;
        int left;
        int np;
        // Reset release with vsync low and href toggling: nothing written.
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        cap_en = 1'b1;
        for (int i = 0; i < 16; i++)
            drive(0, i[0], $urandom_range(0, 255), c);
        @(negedge clk);
        check("init_nwr", mon_addr.size(), 0);
        check("init_we", int'(we), 0);
        check("init_adr", int'(addr), 0);
        check("init_dat", int'(wdata), 0);
        check("init_done", int'(done), 0);
        check("init_ovf", int'(ovf), 0);
        check("init_fcnt", int'(fcnt), 0);
        mon_addr.delete();
        mon_data.delete();
        mon_cyc.delete();
        mon_done.delete();

        // Single line 0A 5C 03 F1.
        stim = '{'h0A, 'h5C, 'h03, 'hF1, -1};
        do_frame(1, 1, 0, "line4");

        // Odd byte dropped at line end.
        stim = '{'h11, 'h22, 'h33, -1, 'h01, 'h23, -1};
        do_frame(1, 1, 0, "odd");

        // Exactly DEPTH pixels.
        for (int l = 0; l < 6; l++) add_line(8, 1'b0);
        do_frame(1, 1, 0, "full");

        // DEPTH+1 pixels: last one dropped, overflow set.
        for (int l = 0; l < 6; l++) add_line(8, l == 2);
        add_line(1, 1'b0);
        do_frame(1, 1, 0, "over");

        // Disabled at frame start, enabled mid-frame: no capture.
        for (int l = 0; l < 3; l++) add_line(4, 1'b0);
        do_frame(0, 1, 0, "off");

        // Next frame captured; overflow cleared at its start.
        for (int l = 0; l < 2; l++) add_line(5, 1'b1);
        do_frame(1, 1, 0, "after");

        // Reset after the first line: remainder of frame ignored.
        for (int l = 0; l < 3; l++) add_line(3, 1'b0);
        do_frame(1, 1, 1, "rstmid");

        // Randomized frames.
        for (int f = 0; f < 8; f++) begin
            left = int'($urandom_range(DEPTH - 20, DEPTH + 6));
            while (left > 0) begin
                np = int'($urandom_range(1, 9));
                if (np > left) np = left;
                add_line(np, 1'($urandom_range(0, 1)));
                left -= np;
            end
            do_frame(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
                     0, "rand");
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
